// File: rtl/pixel_pkg.sv
// Shared screen geometry, colours and sink state encoding for the pixel-plot path.
package pixel_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PIXELS   = SCREEN_W * SCREEN_H;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} sink_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pix_coord_t;
endpackage

// File: rtl/pixel_addr_calc.sv
// Linear framebuffer address y*160 + x built from shifts and adds only.
module pixel_addr_calc #(
  parameter int ADDR_W = 15
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic [ADDR_W-1:0] addr
);
  // 160 = 128 + 32
  assign addr = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
endmodule

// File: rtl/pixel_sink.sv
// Pixel-plot receiver: 2-stage clip/address pipeline into the frame memory, plus an
// optional screen-clear sweep built only when PIXEL_SINK_CLEAR_EN is defined.
module pixel_sink
  import pixel_pkg::*;
#(
  parameter int WIDTH   = SCREEN_W,
  parameter int HEIGHT  = SCREEN_H,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         x,
  input  logic [6:0]         y,
  input  logic [COLOR_W-1:0] color,
  input  logic               plot,
  output logic               ready,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  output logic               clip_flag,
  output logic [ADDR_W-1:0]  write_count
);
  localparam int STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  logic                accept;
  logic [STAGES-1:0]   vld_pipe;
  pix_coord_t          s1_coord;
  logic [COLOR_W-1:0]  s1_color;
  logic                s1_inrange;
  logic [ADDR_W-1:0]   s1_addr;
  logic [ADDR_W-1:0]   s2_addr;
  logic [COLOR_W-1:0]  s2_data;
  logic                s2_inrange;
  logic                plot_we;
  logic                sweep_last;

  assign accept  = plot && ready;
  assign plot_we = vld_pipe[1] && s2_inrange;

  pixel_addr_calc #(.ADDR_W(ADDR_W)) u_addr (
    .x    (s1_coord.x),
    .y    (s1_coord.y),
    .addr (s1_addr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe    <= '0;
      s1_coord    <= '0;
      s1_color    <= '0;
      s1_inrange  <= 1'b0;
      s2_addr     <= '0;
      s2_data     <= '0;
      s2_inrange  <= 1'b0;
      write_count <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        s1_coord   <= '{x: x, y: y};
        s1_color   <= color;
        s1_inrange <= (x < 8'(WIDTH)) && (y < 7'(HEIGHT));
      end
      if (vld_pipe[0]) begin
        s2_addr    <= s1_addr;
        s2_data    <= s1_color;
        s2_inrange <= s1_inrange;
      end
      // Count tracks the write that becomes visible on the next cycle.
      if (sweep_last)
        write_count <= '0;
      else if (vld_pipe[0] && s1_inrange && write_count != '1)
        write_count <= write_count + 1'b1;
    end
  end

  assign clip_flag = vld_pipe[1] && !s2_inrange;

`ifdef PIXEL_SINK_CLEAR_EN
  sink_state_t       state;
  logic [ADDR_W-1:0] sweep;
  logic              drain_cnt;

  assign ready      = (state == IDLE);
  assign busy       = (state == DRAIN) || (state == CLEAR);
  assign sweep_last = (state == CLEAR) && (sweep == LAST_ADDR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sweep     <= '0;
      drain_cnt <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        // Two cycles flush a plot accepted alongside the clear; nothing new enters.
        DRAIN: begin
          if (drain_cnt && !vld_pipe[0]) begin
            state <= CLEAR;
            sweep <= '0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        CLEAR: begin
          if (sweep == LAST_ADDR) begin
            state <= IDLE;
            sweep <= '0;
            done  <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we   = (state == CLEAR) || plot_we;
  assign mem_addr = (state == CLEAR) ? sweep : s2_addr;
  assign mem_data = (state == CLEAR) ? COLOR_W'(BLACK) : s2_data;
`else
  logic unused_clear;

  assign unused_clear = clear;
  assign ready        = 1'b1;
  assign busy         = 1'b0;
  assign done         = 1'b0;
  assign sweep_last   = 1'b0;
  assign mem_we       = plot_we;
  assign mem_addr     = s2_addr;
  assign mem_data     = s2_data;
`endif
endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink; clear-engine scenarios run when PIXEL_SINK_CLEAR_EN is defined.
module tb_pixel_sink;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  color = '0;
  logic        plot = 1'b0;
  logic        clear = 1'b0;
  logic        ready, busy, done, mem_we, clip_flag;
  logic [14:0] mem_addr, write_count;
  logic [2:0]  mem_data;

  typedef struct {
    logic [14:0] a;
    logic [2:0]  d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0, failures = 0;
  int  clip_seen = 0, done_seen = 0, run = 0, max_run = 0;

  pixel_sink u_dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .color(color), .plot(plot),
    .ready(ready), .clear(clear), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .clip_flag(clip_flag), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Output monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (clip_flag) clip_seen++;
      if (done) done_seen++;
      run = mem_we ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (mem_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.a));
          chk("wr_data", 32'(mem_data), 32'(e.d));
        end
      end
    end
  end

  task automatic drive_px(input int px, input int py, input int pc);
    x = 8'(px); y = 7'(py); color = 3'(pc); plot = 1'b1;
    if (px < 160 && py < 120) sb.push_back('{a: 15'(py * 160 + px), d: 3'(pc)});
  endtask

  // One plot with explicit 2-cycle latency checks.
  task automatic plot_one(input int px, input int py, input int pc);
    logic inr;
    inr = (px < 160 && py < 120);
    @(posedge clk); #1;
    drive_px(px, py, pc);
    @(posedge clk); #1;
    plot = 1'b0;
    chk("lat1_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    chk("lat2_we", 32'(mem_we), 32'(inr));
    chk("lat2_clip", 32'(clip_flag), 32'(!inr));
    if (inr) begin
      chk("lat2_addr", 32'(mem_addr), 32'(py * 160 + px));
      chk("lat2_data", 32'(mem_data), 32'(pc));
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #12;
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_clip", 32'(clip_flag), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wcount", 32'(write_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 1);
    @(negedge clk); resetn = 1'b1;

    plot_one(0, 0, 5);
    chk("wcount_1", 32'(write_count), 1);
    plot_one(159, 119, 2);
    chk("wcount_2", 32'(write_count), 2);
    plot_one(160, 5, 7);
    chk("clip_x", 32'(clip_seen), 1);
    chk("wcount_clip_x", 32'(write_count), 2);
    plot_one(3, 120, 1);
    chk("clip_y", 32'(clip_seen), 2);
    chk("wcount_clip_y", 32'(write_count), 2);

    // Back-to-back plots must produce an unbroken run of writes.
    max_run = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive_px(10 + i, 1, i + 1);
      @(posedge clk); #1;
    end
    plot = 1'b0;
    repeat (4) @(posedge clk);
    chk("b2b_run", 32'(max_run), 4);
    chk("wcount_b2b", 32'(write_count), 6);
    chk("sb_empty_b2b", 32'(sb.size()), 0);

`ifdef PIXEL_SINK_CLEAR_EN
    begin
      int  rdy_low;
      bit  got_done;
      rdy_low = 0;
      got_done = 0;
      @(posedge clk); #1;
      drive_px(5, 0, 6);
      clear = 1'b1;
      for (int i = 0; i < 19200; i++) sb.push_back('{a: 15'(i), d: 3'd0});
      @(posedge clk); #1;
      plot = 1'b0; clear = 1'b0;
      chk("clr_busy", 32'(busy), 1);
      chk("clr_ready", 32'(ready), 0);
      for (int i = 0; i < 20000; i++) begin
        @(negedge clk);
        clear = (i == 100);
        if (done) begin got_done = 1; break; end
        if (!ready) rdy_low++;
      end
      clear = 1'b0;
      chk("clr_done_seen", 32'(got_done), 1);
      chk("clr_ready_low_cycles", 32'(rdy_low), 19202);
      chk("clr_done_ready", 32'(ready), 1);
      chk("clr_done_busy", 32'(busy), 0);
      chk("clr_done_wcount", 32'(write_count), 0);
      chk("clr_sb_empty", 32'(sb.size()), 0);
      repeat (3) @(posedge clk);
      chk("clr_done_pulses", 32'(done_seen), 1);

      // Reset in the middle of a sweep.
      got_done = 0;
      @(posedge clk); #1; clear = 1'b1;
      for (int i = 0; i < 19200; i++) sb.push_back('{a: 15'(i), d: 3'd0});
      @(posedge clk); #1; clear = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (mem_we && busy && mem_addr == 15'd1000) begin got_done = 1; break; end
      end
      chk("sweep_reached_1000", 32'(got_done), 1);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_we", 32'(mem_we), 0);
      chk("async_rst_busy", 32'(busy), 0);
      sb.delete();
    end
`else
    @(posedge clk); #1;
    drive_px(5, 0, 6);
    clear = 1'b1;
    @(posedge clk); #1;
    plot = 1'b0; clear = 1'b0;
    chk("noclr_busy", 32'(busy), 0);
    chk("noclr_ready", 32'(ready), 1);
    repeat (6) @(posedge clk);
    chk("noclr_done", 32'(done_seen), 0);
    chk("noclr_sb_empty", 32'(sb.size()), 0);
    chk("noclr_wcount", 32'(write_count), 7);

    // Reset while a write is on the memory port.
    @(posedge clk); #1;
    drive_px(20, 3, 4);
    @(posedge clk); #1; plot = 1'b0;
    @(posedge clk); #1;
    chk("pipe_we_before_rst", 32'(mem_we), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_we", 32'(mem_we), 0);
    sb.delete();
`endif
    @(negedge clk); #2 resetn = 1'b1;
    #1;
    chk("post_rst_ready", 32'(ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_wcount", 32'(write_count), 0);
    plot_one(7, 2, 3);
    chk("post_rst_wcount1", 32'(write_count), 1);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
